// File: rtl/inv_factorial.sv
// Inverse factorial: finds the largest n >= 1 with n! <= the captured value by
// multiplying up an accumulator one factor per cycle.
module inv_factorial #(
  parameter int iwide = 4,
  parameter int owide = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             go,
  input  logic [owide-1:0] in,
  output logic             done,
  output logic             busy,
  output logic [iwide-1:0] out,
  output logic             exact,
  output logic             err
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOOP = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t state_q, state_d;

  // Control -> datapath strobes and datapath -> control status.
  logic load_en, step_en, finish_en;
  logic stop;

  logic [owide-1:0]   in_r_q, in_r_d;
  logic [owide-1:0]   acc_q, acc_d;
  logic [iwide-1:0]   k_q, k_d;
  logic [iwide-1:0]   out_q, out_d;
  logic               exact_q, exact_d;
  logic               err_q, err_d;

  logic [iwide:0]     kp1;
  logic [2*owide-1:0] prod;
  logic               in_zero, prod_ovf, prod_gt, k_cap;

  // ---------------- datapath ----------------
  // k+1 is one bit wider so the step past the cap value cannot wrap.
  assign kp1      = {1'b0, k_q} + (iwide+1)'(1);
  assign prod     = (2*owide)'(acc_q) * (2*owide)'(kp1);
  assign in_zero  = (in_r_q == '0);
  assign prod_ovf = |prod[2*owide-1:owide];
  assign prod_gt  = (prod[owide-1:0] > in_r_q);
  assign k_cap    = (k_q == '1);
  assign stop     = in_zero | prod_ovf | prod_gt | k_cap;

  always_comb begin
    in_r_d = in_r_q;
    acc_d  = acc_q;
    k_d    = k_q;
    if (load_en) begin
      in_r_d = in;
      acc_d  = owide'(1);
      k_d    = iwide'(1);
    end else if (step_en) begin
      acc_d = prod[owide-1:0];
      k_d   = k_q + iwide'(1);
    end
  end

  always_comb begin
    out_d   = out_q;
    exact_d = exact_q;
    err_d   = err_q;
    if (finish_en) begin
      if (in_zero) begin
        out_d   = '0;
        exact_d = 1'b0;
        err_d   = 1'b1;
      end else begin
        out_d   = k_q;
        exact_d = (acc_q == in_r_q);
        err_d   = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_r_q  <= '0;
      acc_q   <= owide'(1);
      k_q     <= iwide'(1);
      out_q   <= '0;
      exact_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      in_r_q  <= in_r_d;
      acc_q   <= acc_d;
      k_q     <= k_d;
      out_q   <= out_d;
      exact_q <= exact_d;
      err_q   <= err_d;
    end
  end

  assign out   = out_q;
  assign exact = exact_q;
  assign err   = err_q;

  // ---------------- control unit ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (go) state_d = S_LOOP;
      S_LOOP:  if (stop) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // busy and done decode the registered state only, so they cannot glitch.
  always_comb begin
    load_en   = 1'b0;
    step_en   = 1'b0;
    finish_en = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state_q)
      S_IDLE: load_en = go;
      S_LOOP: begin
        busy      = 1'b1;
        finish_en = stop;
        step_en   = ~stop;
      end
      S_DONE:  done = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_inv_factorial.sv
// Directed-vector bench for inv_factorial: each task drives one scenario and
// checks results, latency and handshake timing against hand-computed values.
module tb_inv_factorial;

  logic        clk;
  logic        rst;
  logic        go;
  logic [31:0] in_v;
  logic        done;
  logic        busy;
  logic [3:0]  out;
  logic        exact;
  logic        err;

  int checks;
  int failures;

  inv_factorial #(.iwide(4), .owide(32)) dut (
    .clk   (clk),
    .rst   (rst),
    .go    (go),
    .in    (in_v),
    .done  (done),
    .busy  (busy),
    .out   (out),
    .exact (exact),
    .err   (err)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- driver ----------------
  // Pulses go for one edge with the given value and counts edges from the
  // capturing edge (edge 1) to the edge that raises done; then steps one more
  // edge back to IDLE and reports whether done dropped.
  task automatic run_op(input logic [31:0] val, output int lat, output int busy_cnt,
                        output bit to, output logic done_next);
    lat = 0;
    busy_cnt = 0;
    @(negedge clk);
    in_v = val;
    go   = 1'b1;
    @(posedge clk); #1;
    go  = 1'b0;
    lat = 1;
    while (!done && lat < 40) begin
      if (busy) busy_cnt++;
      @(posedge clk); #1;
      lat++;
    end
    to = !done;
    @(posedge clk); #1;
    done_next = done;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst  = 1'b1;
    go   = 1'b0;
    in_v = '0;
    repeat (3) @(negedge clk);
    checks++;
    if ({busy, done, exact, err} !== 4'b0000) begin
      failures++;
      $display("FAIL reset_flags: got busy/done/exact/err=%b want 0000", {busy, done, exact, err});
    end
    checks++;
    if (out !== 4'd0) begin
      failures++;
      $display("FAIL reset_out: got %0d want 0", out);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_exact_120();
    int lat, bc; bit to; logic dn;
    run_op(32'd120, lat, bc, to, dn);
    checks++; if (to !== 1'b0) begin failures++; $display("FAIL t120_timeout: got %0b want 0", to); end
    checks++; if (lat != 6) begin failures++; $display("FAIL t120_latency: got %0d want 6", lat); end
    checks++; if (bc != 5) begin failures++; $display("FAIL t120_busy_cycles: got %0d want 5", bc); end
    checks++; if (out !== 4'd5) begin failures++; $display("FAIL t120_out: got %0d want 5", out); end
    checks++; if (exact !== 1'b1) begin failures++; $display("FAIL t120_exact: got %b want 1", exact); end
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL t120_err: got %b want 0", err); end
    checks++; if (dn !== 1'b0) begin failures++; $display("FAIL t120_done_width: got %b want 0", dn); end
  endtask

  task automatic test_non_exact_700();
    int lat, bc; bit to; logic dn;
    run_op(32'd700, lat, bc, to, dn);
    checks++; if (lat != 6) begin failures++; $display("FAIL t700_latency: got %0d want 6", lat); end
    checks++; if (out !== 4'd5) begin failures++; $display("FAIL t700_out: got %0d want 5", out); end
    checks++; if (exact !== 1'b0) begin failures++; $display("FAIL t700_exact: got %b want 0", exact); end
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL t700_err: got %b want 0", err); end
  endtask

  task automatic test_small();
    int lat, bc; bit to; logic dn;
    run_op(32'd1, lat, bc, to, dn);
    checks++; if (lat != 2) begin failures++; $display("FAIL t1_latency: got %0d want 2", lat); end
    checks++; if (out !== 4'd1) begin failures++; $display("FAIL t1_out: got %0d want 1", out); end
    checks++; if (exact !== 1'b1) begin failures++; $display("FAIL t1_exact: got %b want 1", exact); end
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL t1_err: got %b want 0", err); end
    run_op(32'd0, lat, bc, to, dn);
    checks++; if (lat != 2) begin failures++; $display("FAIL t0_latency: got %0d want 2", lat); end
    checks++; if (out !== 4'd0) begin failures++; $display("FAIL t0_out: got %0d want 0", out); end
    checks++; if (exact !== 1'b0) begin failures++; $display("FAIL t0_exact: got %b want 0", exact); end
    checks++; if (err !== 1'b1) begin failures++; $display("FAIL t0_err: got %b want 1", err); end
  endtask

  task automatic test_large();
    int lat, bc; bit to; logic dn;
    run_op(32'd479001600, lat, bc, to, dn);
    checks++; if (lat != 13) begin failures++; $display("FAIL t12f_latency: got %0d want 13", lat); end
    checks++; if (out !== 4'd12) begin failures++; $display("FAIL t12f_out: got %0d want 12", out); end
    checks++; if (exact !== 1'b1) begin failures++; $display("FAIL t12f_exact: got %b want 1", exact); end
    run_op(32'hFFFF_FFFF, lat, bc, to, dn);
    checks++; if (lat != 13) begin failures++; $display("FAIL tmax_latency: got %0d want 13", lat); end
    checks++; if (out !== 4'd12) begin failures++; $display("FAIL tmax_out: got %0d want 12", out); end
    checks++; if (exact !== 1'b0) begin failures++; $display("FAIL tmax_exact: got %b want 0", exact); end
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL tmax_err: got %b want 0", err); end
  endtask

  task automatic test_ignore_go();
    int lat;
    @(negedge clk);
    in_v = 32'd3628800;
    go   = 1'b1;
    @(posedge clk); #1;
    go  = 1'b0;
    lat = 1;
    while (!done && lat < 40) begin
      // Re-request with a different operand while the loop runs.
      if (lat == 3 || lat == 7) begin
        go   = 1'b1;
        in_v = (lat == 3) ? 32'd24 : 32'd0;
      end else begin
        go = 1'b0;
      end
      @(posedge clk); #1;
      lat++;
    end
    go = 1'b0;
    checks++; if (lat != 11) begin failures++; $display("FAIL ign_latency: got %0d want 11", lat); end
    checks++; if (out !== 4'd10) begin failures++; $display("FAIL ign_out: got %0d want 10", out); end
    checks++; if (exact !== 1'b1) begin failures++; $display("FAIL ign_exact: got %b want 1", exact); end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    int pulses, first_e, last_e, bad_gap;
    logic prev_done;
    pulses = 0; first_e = -1; last_e = -1; bad_gap = 0; prev_done = 1'b0;
    @(negedge clk);
    in_v = 32'd3628800;
    go   = 1'b1;
    // Edge 0 captures; each run is 12 edges (11 to done, 1 back to IDLE).
    for (int e = 0; e < 36; e++) begin
      @(posedge clk); #1;
      if (done) begin
        if (prev_done) bad_gap++;
        if (first_e < 0) first_e = e;
        if (last_e >= 0 && (e - last_e) != 12) bad_gap++;
        last_e = e;
        pulses++;
      end
      prev_done = done;
    end
    @(negedge clk);
    go = 1'b0;
    checks++; if (pulses != 3) begin failures++; $display("FAIL b2b_pulses: got %0d want 3", pulses); end
    checks++; if (first_e != 10) begin failures++; $display("FAIL b2b_first_done: got %0d want 10", first_e); end
    checks++; if (bad_gap != 0) begin failures++; $display("FAIL b2b_spacing: got %0d bad want 0", bad_gap); end
    checks++; if (out !== 4'd10 || exact !== 1'b1) begin
      failures++; $display("FAIL b2b_result: got out=%0d exact=%b want out=10 exact=1", out, exact);
    end
  endtask

  task automatic test_mid_reset();
    int nd, lat, bc; bit to; logic dn;
    nd = 0;
    @(negedge clk);
    in_v = 32'd120;
    go   = 1'b1;
    @(posedge clk); #1;
    go = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    checks++;
    if ({busy, done, exact, err} !== 4'b0000 || out !== 4'd0) begin
      failures++;
      $display("FAIL mid_rst_outputs: got busy/done/exact/err=%b out=%0d want 0000 out=0",
               {busy, done, exact, err}, out);
    end
    repeat (3) begin @(posedge clk); #1; if (done) nd++; end
    @(negedge clk);
    rst = 1'b0;
    repeat (6) begin @(posedge clk); #1; if (done) nd++; end
    checks++; if (nd != 0) begin failures++; $display("FAIL mid_rst_no_done: got %0d pulses want 0", nd); end
    run_op(32'd24, lat, bc, to, dn);
    checks++; if (lat != 5) begin failures++; $display("FAIL post_rst_latency: got %0d want 5", lat); end
    checks++; if (out !== 4'd4) begin failures++; $display("FAIL post_rst_out: got %0d want 4", out); end
    checks++; if (exact !== 1'b1) begin failures++; $display("FAIL post_rst_exact: got %b want 1", exact); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_exact_120();
    test_non_exact_700();
    test_small();
    test_large();
    test_ignore_go();
    test_back_to_back();
    test_mid_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
